// File: rtl/pf_lanectrl_pause_sync_mc.sv
// pf_lanectrl_pause_sync_mc: per-lane pause synchroniser that stretches each pause to a minimum width,
// forces a guard gap after every pause, and can retime its outputs onto the falling clock edge.
module pf_lanectrl_pause_sync_mc #(
    parameter int NUM_LANES        = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PAUSE_CYCLES = 2,
    parameter int GUARD_CYCLES     = 1,
    parameter bit OUTPUT_ON_FALL   = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
    output logic                 PAUSE_ANY,
    output logic [NUM_LANES-1:0] PAUSE_EXTENDED
);
    typedef enum logic [1:0] {IDLE, PAUSE, HOLD, GUARD} state_t;
    localparam logic [3:0] MIN_P = 4'(MIN_PAUSE_CYCLES);
    localparam logic [3:0] GRD   = 4'(GUARD_CYCLES);
    logic [NUM_LANES-1:0] w_p;
    logic [NUM_LANES-1:0] w_p_next;
    logic                 r_any;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic       w_s;
        logic       w_short;
        logic       w_gdone;
        logic       w_pn;
        logic       r_p;
        logic       r_ext;
        logic       r_pend;
        state_t     r_st;
        logic [3:0] r_cnt;
        logic [3:0] r_gcnt;
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = HS_IO_CLK_PAUSE[i];
        end else begin : g_sync
            (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge CLK or negedge RESET_N)
                if (!RESET_N) r_sync <= '0;
                else          r_sync <= SYNC_STAGES'({r_sync, HS_IO_CLK_PAUSE[i]});
            assign w_s = r_sync[SYNC_STAGES-1];
        end
        assign w_short = r_cnt < MIN_P;
        assign w_gdone = r_gcnt == GRD;
        // Next-cycle pause level; shared by the lane register and the PAUSE_ANY register so both stay aligned.
        assign w_pn = (r_st == IDLE)  ? w_s :
                      (r_st == GUARD) ? (w_gdone && (r_pend || w_s)) :
                                        (w_s || w_short);
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_st   <= IDLE;
                r_cnt  <= '0;
                r_gcnt <= '0;
                r_pend <= 1'b0;
                r_p    <= 1'b0;
                r_ext  <= 1'b0;
            end else begin
                r_p   <= w_pn;
                r_ext <= (r_st == PAUSE) && !w_s && w_short;
                case (r_st)
                    IDLE: if (w_s) begin
                        r_st  <= PAUSE;
                        r_cnt <= 4'd1;
                    end
                    PAUSE, HOLD: begin
                        r_cnt <= r_cnt + {3'd0, r_cnt != 4'hF};
                        if (!w_pn) begin
                            r_st   <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
                            r_gcnt <= 4'd1;
                        end else begin
                            r_st <= w_s ? PAUSE : HOLD;
                        end
                    end
                    GUARD: if (w_gdone) begin
                        r_st   <= (r_pend || w_s) ? PAUSE : IDLE;
                        r_cnt  <= 4'd1;
                        r_pend <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + 4'd1;
                        r_pend <= r_pend || w_s;
                    end
                endcase
            end
        end
        assign w_p[i]            = r_p;
        assign w_p_next[i]       = w_pn;
        assign PAUSE_EXTENDED[i] = r_ext;
    end
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) r_any <= 1'b0;
        else          r_any <= |w_p_next;
    if (OUTPUT_ON_FALL) begin : g_fall
        logic [NUM_LANES-1:0] r_p_fall;
        logic                 r_any_fall;
        always_ff @(negedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_p_fall   <= '0;
                r_any_fall <= 1'b0;
            end else begin
                r_p_fall   <= w_p;
                r_any_fall <= r_any;
            end
        end
        assign HS_IO_CLK_PAUSE_SYNC = r_p_fall;
        assign PAUSE_ANY            = r_any_fall;
    end else begin : g_rise
        assign HS_IO_CLK_PAUSE_SYNC = w_p;
        assign PAUSE_ANY            = r_any;
    end
endmodule
